// File: rtl/queue_uart_tx_if.sv
// Queue-side handshake between the output Queue and the UART transmitter:
// data-ready flag and head word from the Queue, pop strobe back to it.
interface queue_uart_tx_if #(
  parameter int BITSIZE = 8
);
  logic               DF;
  logic [BITSIZE-1:0] DI;
  logic               POP;

  modport master (output DF, output DI, input POP);
  modport slave  (input DF, input DI, output POP);
endinterface

// File: rtl/queue_uart_tx.sv
// UART transmitter that drains the output Queue: one pop per word, each word
// sent as start bit, BITSIZE data bits LSB first, one stop bit.
module queue_uart_tx #(
  parameter int BITSIZE = 8,
  parameter int CLKDIV  = 868
) (
  input  logic             CLK,
  input  logic             RST,
  queue_uart_tx_if.slave   q,
  output logic             TXD,
  output logic             BSY
);

  localparam int CNT_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int IDX_W = (BITSIZE > 1) ? $clog2(BITSIZE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKDIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BITSIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [BITSIZE-1:0] sh, sh_n;
  logic [BITSIZE-1:0] sh_shr;
  logic               txd_n, bsy_n, pop_n, pop_r;
  logic               bit_end;

  assign bit_end = (cnt == CNT_LAST);
  assign sh_shr  = sh >> 1;
  assign q.POP   = pop_r;

  // Next-state and registered-output logic; every output is set one edge ahead
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    txd_n   = TXD;
    bsy_n   = BSY;
    pop_n   = 1'b0;

    case (state)
      IDLE: begin
        txd_n = 1'b1;
        bsy_n = 1'b0;
        if (q.DF) begin
          sh_n    = q.DI;
          pop_n   = 1'b1;
          txd_n   = 1'b0;
          bsy_n   = 1'b1;
          cnt_n   = '0;
          idx_n   = '0;
          state_n = START;
        end
      end

      START: begin
        if (bit_end) begin
          cnt_n   = '0;
          txd_n   = sh[0];
          state_n = DATA;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (idx == IDX_LAST) begin
            txd_n   = 1'b1;
            state_n = STOP;
          end else begin
            // Shift so the next data bit is always at position 0
            idx_n = idx + IDX_W'(1);
            sh_n  = sh_shr;
            txd_n = sh_shr[0];
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      STOP: begin
        if (bit_end) begin
          cnt_n   = '0;
          txd_n   = 1'b1;
          bsy_n   = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      default: begin
        txd_n   = 1'b1;
        bsy_n   = 1'b0;
        cnt_n   = '0;
        idx_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      TXD   <= 1'b1;
      BSY   <= 1'b0;
      pop_r <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
      TXD   <= txd_n;
      BSY   <= bsy_n;
      pop_r <= pop_n;
    end
  end

endmodule

// File: tb/tb_queue_uart_tx.sv
// Directed bench for queue_uart_tx with a small Queue model and a UART monitor.
module tb_queue_uart_tx;
  localparam int BITSIZE = 8;
  localparam int CLKDIV  = 4;

  logic clk = 1'b0;
  logic rst;
  logic txd, bsy;
  always #5 clk = ~clk;

  queue_uart_tx_if #(.BITSIZE(BITSIZE)) qif ();

  queue_uart_tx #(.BITSIZE(BITSIZE), .CLKDIV(CLKDIV)) dut (
    .CLK(clk),
    .RST(rst),
    .q  (qif.slave),
    .TXD(txd),
    .BSY(bsy)
  );

  int checks = 0;
  int errors = 0;

  // Manual drive for directed cases, Queue model for the streaming case
  logic       use_q = 1'b0;
  logic       m_df  = 1'b0;
  logic [7:0] m_di  = 8'h00;
  logic [7:0] qarr [0:31];
  int         wp = 0;
  int         rp = 0;

  assign qif.DF = use_q ? (wp != rp) : m_df;
  assign qif.DI = use_q ? qarr[rp[4:0]] : m_di;

  always @(posedge clk) if (use_q && qif.POP === 1'b1) rp <= rp + 1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pop_cnt = 0;
  int pop_df_err = 0;
  int pop_cyc [0:63];
  always @(negedge clk) begin
    if (qif.POP === 1'b1) begin
      if (pop_cnt < 64) pop_cyc[pop_cnt] = cyc;
      pop_cnt++;
      if (qif.DF !== 1'b1) pop_df_err++;
    end
  end

  // UART receiver: samples each bit in the middle of its CLKDIV window
  logic [7:0] rx_buf [0:63];
  int rx_cnt = 0;
  int stop_err = 0;
  always begin
    logic [7:0] b;
    @(negedge clk);
    if (txd === 1'b0 && rst === 1'b0) begin
      repeat (CLKDIV + CLKDIV / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        b[i] = txd;
        if (i < 7) repeat (CLKDIV) @(negedge clk);
      end
      repeat (CLKDIV) @(negedge clk);
      if (txd !== 1'b1) stop_err++;
      if (rx_cnt < 64) rx_buf[rx_cnt] = b;
      rx_cnt++;
    end
  end

  task automatic test_reset;
    int p0;
    rst  = 1'b1;
    m_df = 1'b1;
    m_di = 8'h5A;
    p0   = pop_cnt;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (txd !== 1'b1 || qif.POP !== 1'b0 || bsy !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs c%0d: txd=%b pop=%b bsy=%b, required 1 0 0", c, txd, qif.POP, bsy);
      end
    end
    checks++;
    if (pop_cnt !== p0) begin
      errors++;
      $display("FAIL reset_no_pop: pops=%0d, required %0d", pop_cnt - p0, 0);
    end
    m_df = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (txd !== 1'b1 || bsy !== 1'b0 || pop_cnt !== p0) begin
      errors++;
      $display("FAIL reset_release_idle: txd=%b bsy=%b pops=%0d, required 1 0 0", txd, bsy, pop_cnt - p0);
    end
  endtask

  task automatic test_single;
    int p0, r0;
    logic [9:0] fr;
    logic exp_txd, exp_bsy, exp_pop;
    fr = {1'b1, 8'h55, 1'b0};
    p0 = pop_cnt;
    r0 = rx_cnt;
    @(negedge clk);
    m_di = 8'h55;
    m_df = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 48; c++) begin
      exp_txd = (c < 40) ? fr[c / 4] : 1'b1;
      exp_bsy = (c < 40);
      exp_pop = (c == 0);
      checks++;
      if (txd !== exp_txd || bsy !== exp_bsy || qif.POP !== exp_pop) begin
        errors++;
        $display("FAIL single_wave c%0d: txd=%b bsy=%b pop=%b, required %b %b %b",
                 c, txd, bsy, qif.POP, exp_txd, exp_bsy, exp_pop);
      end
      @(posedge clk);
      #1;
      if (c == 0) m_df = 1'b0;
    end
    checks++;
    if (pop_cnt - p0 != 1) begin
      errors++;
      $display("FAIL single_pop_count: got %0d, required 1", pop_cnt - p0);
    end
    checks++;
    if (rx_cnt - r0 != 1 || rx_buf[r0] !== 8'h55) begin
      errors++;
      $display("FAIL single_decode: frames=%0d byte=%h, required 1 55", rx_cnt - r0, rx_buf[r0]);
    end
  endtask

  task automatic test_back_to_back;
    int p0, r0;
    p0 = pop_cnt;
    r0 = rx_cnt;
    @(negedge clk);
    m_di = 8'hA3;
    m_df = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 90; c++) begin
      if (c == 39) begin
        checks++;
        if (txd !== 1'b1 || bsy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_stop: txd=%b bsy=%b, required 1 1", txd, bsy);
        end
      end
      if (c == 40) begin
        checks++;
        if (txd !== 1'b1 || bsy !== 1'b0 || qif.POP !== 1'b0) begin
          errors++;
          $display("FAIL b2b_idle_gap: txd=%b bsy=%b pop=%b, required 1 0 0", txd, bsy, qif.POP);
        end
      end
      if (c == 41) begin
        checks++;
        if (txd !== 1'b0 || bsy !== 1'b1 || qif.POP !== 1'b1) begin
          errors++;
          $display("FAIL b2b_second_start: txd=%b bsy=%b pop=%b, required 0 1 1", txd, bsy, qif.POP);
        end
      end
      @(posedge clk);
      #1;
      if (c == 0) m_di = 8'h0F;
      if (c == 41) m_df = 1'b0;
    end
    checks++;
    if (pop_cnt - p0 != 2) begin
      errors++;
      $display("FAIL b2b_pop_count: got %0d, required 2", pop_cnt - p0);
    end else begin
      checks++;
      if (pop_cyc[p0 + 1] - pop_cyc[p0] != 41) begin
        errors++;
        $display("FAIL b2b_pop_spacing: got %0d, required 41", pop_cyc[p0 + 1] - pop_cyc[p0]);
      end
    end
    checks++;
    if (rx_cnt - r0 != 2 || rx_buf[r0] !== 8'hA3 || rx_buf[r0 + 1] !== 8'h0F) begin
      errors++;
      $display("FAIL b2b_decode: frames=%0d bytes=%h %h, required 2 a3 0f",
               rx_cnt - r0, rx_buf[r0], rx_buf[r0 + 1]);
    end
  endtask

  task automatic test_di_capture;
    int r0;
    r0 = rx_cnt;
    @(negedge clk);
    m_di = 8'hFF;
    m_df = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    m_di = 8'h00;
    m_df = 1'b0;
    repeat (46) @(posedge clk);
    #1;
    checks++;
    if (rx_cnt - r0 != 1 || rx_buf[r0] !== 8'hFF) begin
      errors++;
      $display("FAIL di_capture: frames=%0d byte=%h, required 1 ff", rx_cnt - r0, rx_buf[r0]);
    end
    checks++;
    if (txd !== 1'b1 || bsy !== 1'b0) begin
      errors++;
      $display("FAIL di_capture_idle: txd=%b bsy=%b, required 1 0", txd, bsy);
    end
  endtask

  task automatic test_mid_reset;
    int p0;
    p0 = pop_cnt;
    @(negedge clk);
    m_di = 8'hC6;
    m_df = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    m_df = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    checks++;
    if (txd !== 1'b0 || bsy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_bit3: txd=%b bsy=%b, required 0 1", txd, bsy);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (txd !== 1'b1 || bsy !== 1'b0 || qif.POP !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: txd=%b bsy=%b pop=%b, required 1 0 0", txd, bsy, qif.POP);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      checks++;
      if (txd !== 1'b1 || bsy !== 1'b0) begin
        errors++;
        $display("FAIL midrst_idle c%0d: txd=%b bsy=%b, required 1 0", c, txd, bsy);
      end
    end
    checks++;
    if (pop_cnt - p0 != 1) begin
      errors++;
      $display("FAIL midrst_pops: got %0d, required 1", pop_cnt - p0);
    end
  endtask

  task automatic test_queue_stream;
    int p0, r0, d0, s0, t;
    p0 = pop_cnt;
    r0 = rx_cnt;
    d0 = pop_df_err;
    s0 = stop_err;
    @(negedge clk);
    for (int i = 0; i < 16; i++) qarr[i] = 8'($urandom_range(0, 255));
    use_q = 1'b1;
    wp    = 16;
    t     = 0;
    while (rx_cnt - r0 < 16 && t < 16 * 45 + 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (rx_cnt - r0 != 16) begin
      errors++;
      $display("FAIL stream_frames: got %0d, required 16", rx_cnt - r0);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rx_buf[r0 + i] !== qarr[i]) begin
        errors++;
        $display("FAIL stream_byte%0d: got %h, required %h", i, rx_buf[r0 + i], qarr[i]);
      end
    end
    repeat (50) @(negedge clk);
    checks++;
    if (pop_cnt - p0 != 16 || rp != 16) begin
      errors++;
      $display("FAIL stream_pops: pops=%0d rp=%0d, required 16 16", pop_cnt - p0, rp);
    end
    checks++;
    if (pop_df_err != d0) begin
      errors++;
      $display("FAIL stream_pop_without_df: got %0d, required 0", pop_df_err - d0);
    end
    checks++;
    if (stop_err != s0) begin
      errors++;
      $display("FAIL stream_stop_bits: bad=%0d, required 0", stop_err - s0);
    end
    checks++;
    if (txd !== 1'b1 || bsy !== 1'b0) begin
      errors++;
      $display("FAIL stream_final_idle: txd=%b bsy=%b, required 1 0", txd, bsy);
    end
    use_q = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_di_capture();
    test_mid_reset();
    test_queue_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
